alu_issue_ctrl: RTL and testbench

Sequential front-end for the team's combinational 32-bit ALU (oper codes AND=4'b0000, OR=4'b0001, ADD=4'b0010, XOR=4'b0011; other codes produce 0).
- Accepts decoded RISC-V R/I-type arithmetic requests over a valid/ready handshake.
- Encodes funct3/funct7 into the ALU oper code and drives registered operands into the ALU.
- Captures the ALU result and presents it on a valid/ready response port.
- Sits between the decode stage and the ALU instance.

---
 rtl/alu_pkg.sv | 24 ++
 rtl/alu_oper_dec.sv | 28 ++
 rtl/alu_issue_ctrl.sv | 113 +++++++++++
 tb/tb_alu_issue_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types and decode constants for the ALU issue path.
package alu_pkg;

  typedef enum logic [3:0] {
    AND     = 4'b0000,
    OR      = 4'b0001,
    ADD     = 4'b0010,
    XOR     = 4'b0011,
    ILLEGAL = 4'b1111
  } alu_oper_e;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;
  localparam logic [6:0] F7_BASE = 7'b0000000;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_RESP
  } issue_state_e;

endpackage

// File: rtl/alu_oper_dec.sv
// Combinational funct3/funct7 decode to ALU oper code; also used by the decode stage.
module alu_oper_dec
  import alu_pkg::*;
(
  input  logic [2:0] funct3_i,
  input  logic [6:0] funct7_i,
  input  logic       is_imm_i,
  output alu_oper_e  oper_o,
  output logic       illegal_o
);

  logic f7_ok;

  always_comb begin
    // I-type has no funct7; R-type only accepts the base encoding
    f7_ok  = is_imm_i || (funct7_i == F7_BASE);
    oper_o = ILLEGAL;
    case (funct3_i)
      F3_ADD:  if (f7_ok) oper_o = ADD;
      F3_XOR:  if (f7_ok) oper_o = XOR;
      F3_OR:   if (f7_ok) oper_o = OR;
      F3_AND:  if (f7_ok) oper_o = AND;
      default: oper_o = ILLEGAL;
    endcase
    illegal_o = (oper_o == ILLEGAL);
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Valid/ready issue front-end for the combinational ALU.
// Optional zero flag on the response is enabled with `define ALU_ZERO_FLAG_EN.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH        = 32,
  parameter logic [3:0]  ILLEGAL_OPER = 4'b1111
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_funct3,
  input  logic [6:0]       req_funct7,
  input  logic             req_is_imm,
  input  logic [WIDTH-1:0] req_rs1,
  input  logic [WIDTH-1:0] req_rs2,
  input  logic [WIDTH-1:0] req_imm,
  output logic [3:0]       alu_oper,
  output logic [WIDTH-1:0] alu_rs1,
  output logic [WIDTH-1:0] alu_rs2,
  input  logic [WIDTH-1:0] alu_result,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_illegal,
  output logic             rsp_zero
);

  issue_state_e     state_q, state_d;
  alu_oper_e        dec_oper;
  logic             dec_illegal;
  logic             accept;
  logic [3:0]       oper_q;
  logic [WIDTH-1:0] rs1_q, rs2_q, data_q;
  logic             ill_q, rsp_ill_q;

  alu_oper_dec u_dec (
    .funct3_i  (req_funct3),
    .funct7_i  (req_funct7),
    .is_imm_i  (req_is_imm),
    .oper_o    (dec_oper),
    .illegal_o (dec_illegal)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = S_EXEC;
      end
      S_EXEC: state_d = S_RESP;
      S_RESP: begin
        rsp_valid = 1'b1;
        req_ready = rsp_ready;
        if (rsp_ready) state_d = req_valid ? S_EXEC : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (rst) req_ready = 1'b0;
  end

  assign accept = req_valid && req_ready;

  // A separate illegal bit keeps forcing correct even if ILLEGAL_OPER is overridden
  always_ff @(posedge clk) begin
    if (rst) begin
      oper_q    <= ILLEGAL_OPER;
      rs1_q     <= '0;
      rs2_q     <= '0;
      ill_q     <= 1'b0;
      data_q    <= '0;
      rsp_ill_q <= 1'b0;
    end else begin
      if (accept) begin
        oper_q <= dec_illegal ? ILLEGAL_OPER : dec_oper;
        rs1_q  <= req_rs1;
        rs2_q  <= req_is_imm ? req_imm : req_rs2;
        ill_q  <= dec_illegal;
      end
      if (state_q == S_EXEC) begin
        data_q    <= ill_q ? '0 : alu_result;
        rsp_ill_q <= ill_q;
      end
    end
  end

`ifdef ALU_ZERO_FLAG_EN
  logic zero_q;
  always_ff @(posedge clk) begin
    if (rst)                     zero_q <= 1'b0;
    else if (state_q == S_EXEC)  zero_q <= !ill_q && (alu_result == '0);
  end
  assign rsp_zero = zero_q;
`else
  assign rsp_zero = 1'b0;
`endif

  assign alu_oper    = oper_q;
  assign alu_rs1     = rs1_q;
  assign alu_rs2     = rs2_q;
  assign rsp_data    = data_q;
  assign rsp_illegal = rsp_ill_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: vector table plus scoreboard of responses.
module tb_alu_issue_ctrl;

  logic        clk, rst;
  logic        req_valid, req_ready, req_is_imm;
  logic [2:0]  req_funct3;
  logic [6:0]  req_funct7;
  logic [31:0] req_rs1, req_rs2, req_imm;
  logic [3:0]  alu_oper;
  logic [31:0] alu_rs1, alu_rs2, alu_result;
  logic        rsp_valid, rsp_ready, rsp_illegal, rsp_zero;
  logic [31:0] rsp_data;

  alu_issue_ctrl #(.WIDTH(32), .ILLEGAL_OPER(4'b1111)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_funct3(req_funct3), .req_funct7(req_funct7), .req_is_imm(req_is_imm),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .req_imm(req_imm),
    .alu_oper(alu_oper), .alu_rs1(alu_rs1), .alu_rs2(alu_rs2), .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_illegal(rsp_illegal), .rsp_zero(rsp_zero)
  );

  // ALU model; unknown codes return a non-zero pattern so the forced-zero path is exercised
  always_comb begin
    case (alu_oper)
      4'b0000: alu_result = alu_rs1 & alu_rs2;
      4'b0001: alu_result = alu_rs1 | alu_rs2;
      4'b0010: alu_result = alu_rs1 + alu_rs2;
      4'b0011: alu_result = alu_rs1 ^ alu_rs2;
      default: alu_result = 32'hDEADBEEF;
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic        imm;
    logic [31:0] rs1, rs2, immv;
    logic [3:0]  oper;
    logic [31:0] data;
    logic        ill;
  } vec_t;

  typedef struct packed {
    logic [31:0] data;
    logic        ill;
    logic        zero;
  } exp_t;

  localparam int NV = 9;
  vec_t vecs [NV];
  exp_t sb [$];
  exp_t cur_exp, pop_e;
  int   rsp_times [$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h required 0x%08h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic zf(input logic [31:0] d, input logic ill);
`ifdef ALU_ZERO_FLAG_EN
    return !ill && (d == 32'h0);
`else
    return 1'b0;
`endif
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    while (!req_ready && n < 20) begin step(); n++; end
    chk(name, req_ready, 1);
  endtask

  task automatic drive(input logic [2:0] f3, input logic [6:0] f7, input logic imm,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] iv,
                       input logic [31:0] d, input logic ill);
    req_funct3 = f3; req_funct7 = f7; req_is_imm = imm;
    req_rs1 = a; req_rs2 = b; req_imm = iv;
    cur_exp.data = d; cur_exp.ill = ill; cur_exp.zero = zf(d, ill);
    req_valid = 1'b1;
  endtask

  // Scoreboard: push on request accept, pop and compare on response handshake
  always @(negedge clk) begin
    if (rst) sb.delete();
    else begin
      if (req_valid && req_ready) sb.push_back(cur_exp);
      if (rsp_valid && rsp_ready) begin
        rsp_times.push_back(cyc);
        if (sb.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_rsp: got data 0x%08h, required no response", rsp_data);
        end else begin
          pop_e = sb.pop_front();
          chk("rsp_data", rsp_data, pop_e.data);
          chk("rsp_illegal", {31'b0, rsp_illegal}, {31'b0, pop_e.ill});
          chk("rsp_zero", {31'b0, rsp_zero}, {31'b0, pop_e.zero});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    int   t;
    //          f3      f7          imm  rs1           rs2           imm           oper     data          ill
    vecs[0] = '{3'b000, 7'b0000000, 0, 32'd5,        32'd7,        32'd0,        4'b0010, 32'd12,       0};
    vecs[1] = '{3'b000, 7'b0100000, 1, 32'hFFFFFFFF, 32'h00012345, 32'd1,        4'b0010, 32'h0,        0};
    vecs[2] = '{3'b100, 7'b0000000, 0, 32'hF0F0F0F0, 32'h0F0F0F0F, 32'd0,        4'b0011, 32'hFFFFFFFF, 0};
    vecs[3] = '{3'b000, 7'b0100000, 0, 32'd9,        32'd4,        32'd0,        4'b1111, 32'h0,        1};
    vecs[4] = '{3'b001, 7'b0000000, 0, 32'd9,        32'd4,        32'd0,        4'b1111, 32'h0,        1};
    vecs[5] = '{3'b110, 7'b0000000, 0, 32'h000000A0, 32'h0000000B, 32'd0,        4'b0001, 32'h000000AB, 0};
    vecs[6] = '{3'b111, 7'b1111111, 1, 32'h0000003C, 32'h0,        32'h000000F0, 4'b0000, 32'h00000030, 0};
    vecs[7] = '{3'b100, 7'b0000001, 0, 32'h1,        32'h2,        32'd0,        4'b1111, 32'h0,        1};
    vecs[8] = '{3'b010, 7'b0000000, 1, 32'h1,        32'h2,        32'd7,        4'b1111, 32'h0,        1};

    rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b1;
    req_funct3 = '0; req_funct7 = '0; req_is_imm = 1'b0;
    req_rs1 = '0; req_rs2 = '0; req_imm = '0;
    step(); step();
    chk("reset_req_ready", {31'b0, req_ready}, 0);
    chk("reset_rsp_valid", {31'b0, rsp_valid}, 0);
    chk("reset_alu_oper", {28'b0, alu_oper}, 32'hF);
    chk("reset_alu_rs1", alu_rs1, 0);
    chk("reset_rsp_data", rsp_data, 0);
    rst = 1'b0; #1;
    chk("post_reset_ready", {31'b0, req_ready}, 1);

    for (int i = 0; i < NV; i++) begin
      v = vecs[i];
      drive(v.f3, v.f7, v.imm, v.rs1, v.rs2, v.immv, v.data, v.ill);
      wait_ready("vec_accept");
      step(); req_valid = 1'b0;
      chk("exec_oper", {28'b0, alu_oper}, {28'b0, v.oper});
      chk("exec_rs1", alu_rs1, v.rs1);
      chk("exec_rs2", alu_rs2, v.imm ? v.immv : v.rs2);
      chk("exec_req_ready", {31'b0, req_ready}, 0);
      step();
      chk("rsp_valid_n2", {31'b0, rsp_valid}, 1);
      step();
      chk("idle_rsp_valid", {31'b0, rsp_valid}, 0);
      chk("oper_hold", {28'b0, alu_oper}, {28'b0, v.oper});
    end

    // Backpressure: AND 0xFF & 0x0F held for 5 cycles, competing request refused
    rsp_ready = 1'b0;
    drive(3'b111, 7'b0, 1'b0, 32'hFF, 32'h0F, 32'h0, 32'h0F, 1'b0);
    wait_ready("bp_accept");
    step();
    drive(3'b000, 7'b0, 1'b0, 32'd1, 32'd1, 32'h0, 32'd2, 1'b0);
    step();
    for (int k = 0; k < 5; k++) begin
      chk("bp_rsp_valid", {31'b0, rsp_valid}, 1);
      chk("bp_rsp_data", rsp_data, 32'h0F);
      chk("bp_req_ready", {31'b0, req_ready}, 0);
      step();
    end
    req_valid = 1'b0; rsp_ready = 1'b1;
    step();
    chk("bp_release_idle", {31'b0, req_ready}, 1);
    chk("bp_release_valid", {31'b0, rsp_valid}, 0);

    // Back-to-back: OR then AND with the second accepted in the first's RESP cycle
    drive(3'b110, 7'b0, 1'b0, 32'h1, 32'h2, 32'h0, 32'h3, 1'b0);
    wait_ready("b2b_accept");
    step();
    drive(3'b111, 7'b0, 1'b0, 32'h3, 32'h1, 32'h0, 32'h1, 1'b0);
    step();
    chk("b2b_resp_ready", {31'b0, req_ready}, 1);
    chk("b2b_rsp_data0", rsp_data, 32'h3);
    t = rsp_times.size();
    step(); req_valid = 1'b0;
    chk("b2b_second_oper", {28'b0, alu_oper}, 32'h0);
    step(); step();
    if (rsp_times.size() >= t + 2)
      chk("b2b_spacing", rsp_times[t + 1] - rsp_times[t], 2);
    else
      chk("b2b_rsp_count", rsp_times.size(), t + 2);

    // Reset during EXEC aborts the op with no response
    drive(3'b000, 7'b0, 1'b0, 32'd2, 32'd3, 32'h0, 32'd5, 1'b0);
    wait_ready("rst_accept");
    step(); req_valid = 1'b0; rst = 1'b1;
    step();
    chk("rst_mid_rsp_valid", {31'b0, rsp_valid}, 0);
    chk("rst_mid_oper", {28'b0, alu_oper}, 32'hF);
    chk("rst_mid_req_ready", {31'b0, req_ready}, 0);
    rst = 1'b0; #1;
    chk("rst_mid_ready_after", {31'b0, req_ready}, 1);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("rst_no_rsp", {31'b0, rsp_valid}, 0);
    end

    chk("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
